// File: rtl/psoc_audio_pkg.sv
// Shared audio frame definitions for the FIFO and psoc_dac.
// A frame is a stereo pair of signed 24-bit samples: right in the upper half, left in the lower.
package psoc_audio_pkg;
    localparam int SAMPLE_W  = 24;
    localparam int FRAME_W   = 2 * SAMPLE_W;
    localparam int RIGHT_MSB = FRAME_W - 1;
    localparam int RIGHT_LSB = SAMPLE_W;
    localparam int LEFT_MSB  = SAMPLE_W - 1;
    localparam int LEFT_LSB  = 0;

    typedef logic [FRAME_W-1:0]  frame_t;
    typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/psoc_audio_fifo_if.sv
// Producer-write and DAC-pop handshake of the audio FIFO.
interface psoc_audio_fifo_if;
    import psoc_audio_pkg::*;

    logic   wr_valid;
    frame_t wr_data;
    logic   wr_ready;
    logic   fifo_ready;
    frame_t fifo_data;

    modport master (output wr_valid, wr_data, fifo_ready, input wr_ready, fifo_data);
    modport slave  (input wr_valid, wr_data, fifo_ready, output wr_ready, fifo_data);
endinterface

// File: rtl/psoc_audio_fifo_ram.sv
// Frame storage: one synchronous write port, one asynchronous read port (distributed RAM).
module psoc_audio_fifo_ram
    import psoc_audio_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  frame_t        wdata,
    input  logic [AW-1:0] raddr,
    output frame_t        rdata
);
    frame_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/psoc_audio_fifo.sv
// First-word-fall-through stereo frame FIFO feeding the DAC; outputs silence when empty.
// Define PSOC_AUDIO_FIFO_UNDERRUN_CNT_EN to add the saturating underrun counter.
module psoc_audio_fifo
    import psoc_audio_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int LOW_THRESH = 16,
    localparam int AW        = $clog2(DEPTH),
    localparam int LW        = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    psoc_audio_fifo_if.slave  bus,
    output logic [LW-1:0]     level,
    output logic              empty,
    output logic              full,
`ifdef PSOC_AUDIO_FIFO_UNDERRUN_CNT_EN
    input  logic              underrun_clr,
    output logic [15:0]       underrun_cnt,
`endif
    output logic              irq_low
);
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr, rd_ptr;
    logic        do_wr, do_rd;
    frame_t      rd_frame;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (level == LW'(DEPTH));
    assign irq_low = (level <= LW'(LOW_THRESH));

    assign bus.wr_ready  = !full;
    assign bus.fifo_data = empty ? '0 : rd_frame;

    assign do_wr = bus.wr_valid && !full  && !flush;
    assign do_rd = bus.fifo_ready && !empty && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    psoc_audio_fifo_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (do_wr),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.wr_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_frame)
    );

`ifdef PSOC_AUDIO_FIFO_UNDERRUN_CNT_EN
    // A pop strobe against an empty FIFO counts as an underrun, flush or not.
    always_ff @(posedge clk) begin
        if (rst || underrun_clr)
            underrun_cnt <= '0;
        else if (bus.fifo_ready && empty && underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_psoc_audio_fifo.sv
// Directed bench for psoc_audio_fifo: queue scoreboard of accepted frames, checked on every pop.
module tb_psoc_audio_fifo;
    import psoc_audio_pkg::*;

    localparam int DEPTH = 64;
    localparam int LOW   = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic [LW-1:0] level;
    logic empty, full, irq_low;
    always #5 clk = ~clk;

    psoc_audio_fifo_if bus ();

`ifdef PSOC_AUDIO_FIFO_UNDERRUN_CNT_EN
    logic        underrun_clr = 1'b0;
    logic [15:0] underrun_cnt;
    int          ucnt = 0;
`endif

    psoc_audio_fifo #(.DEPTH(DEPTH), .LOW_THRESH(LOW)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .bus          (bus.slave),
        .level        (level),
        .empty        (empty),
        .full         (full),
`ifdef PSOC_AUDIO_FIFO_UNDERRUN_CNT_EN
        .underrun_clr (underrun_clr),
        .underrun_cnt (underrun_cnt),
`endif
        .irq_low      (irq_low)
    );

    frame_t sb [$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        check("level",     48'(level),         48'(sb.size()));
        check("empty",     48'(empty),         48'(sb.size() == 0));
        check("full",      48'(full),          48'(sb.size() == DEPTH));
        check("wr_ready",  48'(bus.wr_ready),  48'(sb.size() != DEPTH));
        check("irq_low",   48'(irq_low),       48'(sb.size() <= LOW));
        check("fifo_data", bus.fifo_data,      (sb.size() == 0) ? 48'h0 : sb[0]);
`ifdef PSOC_AUDIO_FIFO_UNDERRUN_CNT_EN
        check("underrun_cnt", 48'(underrun_cnt), 48'(ucnt));
`endif
    endtask

    // Drive one cycle, update the model with what the edge should do, then check after the edge.
    task automatic cycle(input logic wv, input frame_t wd, input logic rdy, input logic fl, input logic clr);
        logic push;
        bus.wr_valid   = wv;
        bus.wr_data    = wd;
        bus.fifo_ready = rdy;
        flush          = fl;
`ifdef PSOC_AUDIO_FIFO_UNDERRUN_CNT_EN
        underrun_clr = clr;
        if (clr) ucnt = 0;
        else if (rdy && sb.size() == 0 && ucnt != 16'hFFFF) ucnt++;
`endif
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (rdy && sb.size() != 0) check("pop_data", bus.fifo_data, sb[0]);
            push = wv && (sb.size() < DEPTH);
            if (rdy && sb.size() != 0) void'(sb.pop_front());
            if (push) sb.push_back(wd);
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.fifo_ready = 1'b0;
        flush          = 1'b0;
        sb.delete();
`ifdef PSOC_AUDIO_FIFO_UNDERRUN_CNT_EN
        underrun_clr = 1'b0;
        ucnt = 0;
`endif
        @(posedge clk);
        #1;
        check_state();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // single write becomes visible right after its edge
        cycle(1'b1, 48'h000001_FFFFFF, 1'b0, 1'b0, 1'b0);
        check("first_frame", bus.fifo_data, 48'h000001_FFFFFF);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // fill to full, rejected 65th write alongside a pop, drain in order
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, frame_t'(i), 1'b0, 1'b0, 1'b0);
        check("full_flag", 48'(full), 48'h1);
        cycle(1'b1, frame_t'(64), 1'b1, 1'b0, 1'b0);
        check("reject_when_full", 48'(level), 48'd63);
        for (int i = 1; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("drained_silence", bus.fifo_data, 48'h0);

        // steady level 10 with simultaneous write/pop across pointer wrap
        for (int i = 0; i < 10; i++) cycle(1'b1, frame_t'(48'h100 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) cycle(1'b1, frame_t'(48'hA00000_000000 + i), 1'b1, 1'b0, 1'b0);
        check("steady_level", 48'(level), 48'd10);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // underruns: pointers hold, silence stays out; a same-cycle write still lands
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        end
`ifdef PSOC_AUDIO_FIFO_UNDERRUN_CNT_EN
        check("underrun_3", 48'(underrun_cnt), 48'd3);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("underrun_clr_prio", 48'(underrun_cnt), 48'd0);
        for (int i = 0; i < 70000; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("underrun_sat", 48'(underrun_cnt), 48'hFFFF);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
`endif
        cycle(1'b1, 48'h7FFFFF_800000, 1'b1, 1'b0, 1'b0);
        check("underrun_wr_level", 48'(level), 48'd1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // flush beats same-cycle write and pop
        for (int i = 0; i < 40; i++) cycle(1'b1, frame_t'(48'h200 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 48'hDEAD00_BEEF00, 1'b1, 1'b1, 1'b0);
        check("flush_level", 48'(level), 48'd0);
        check("flush_irq", 48'(irq_low), 48'd1);
        cycle(1'b1, 48'h123456_654321, 1'b0, 1'b0, 1'b0);
        check("post_flush_head", bus.fifo_data, 48'h123456_654321);

        // irq_low threshold crossing 17 -> 16 -> 17
        for (int i = 0; i < 16; i++) cycle(1'b1, frame_t'(48'h300 + i), 1'b0, 1'b0, 1'b0);
        check("irq_at_17", 48'(irq_low), 48'd0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("irq_at_16", 48'(irq_low), 48'd1);
        cycle(1'b1, frame_t'(48'h400), 1'b0, 1'b0, 1'b0);
        check("irq_back_17", 48'(irq_low), 48'd0);

        // reset mid-stream discards contents
        do_reset();
        check("rst_data", bus.fifo_data, 48'h0);
        cycle(1'b1, 48'h0000AA_0000BB, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
